sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 104 ++++++++++
 tb/tb_sync_fifo.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO: default geometry, helpers that
// derive pointer and occupancy-count widths from a depth, and the per-cycle
// operation encoding used to update the occupancy count.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Pointer width addresses DEPTH entries; the count needs one extra bit so
  // that "completely full" (count == DEPTH) is representable.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  localparam int DEF_PTR_W = ptr_width(DEF_FIFO_DEPTH);
  localparam int DEF_CNT_W = cnt_width(DEF_FIFO_DEPTH);

  // Accepted operations in one cycle, packed as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : fifo_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read data and registered handshake flags.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   data_in      write data
//   wr_en        write request
//   rd_en        read request
//   data_out     read data, valid the cycle after an accepted read, held otherwise
//   wr_ack       previous-cycle write was accepted
//   overflow     previous-cycle write was rejected because the FIFO was full
//   underflow    previous-cycle read was rejected because the FIFO was empty
//   full, empty, almostfull, almostempty
//                combinational status decoded from the occupancy count
// -----------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic     wr_accept;
  logic     rd_accept;
  fifo_op_e op;

  // A write while full is dropped even if a read frees a slot in the same
  // cycle; a read while empty is dropped even if a write fills one. Both
  // decisions are made from the occupancy at the edge, never from the
  // other request.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;
  assign op        = fifo_op_e'({wr_accept, rd_accept});

  // Status decode. Count is cleared asynchronously, so these flags show the
  // empty state for the whole time rst is held.
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == CNT_W'(0));
  assign almostfull  = (count == CNT_W'(FIFO_DEPTH - 1));
  assign almostempty = (count == CNT_W'(1));

  // NOTE: storage has no reset; stale entries are unreachable once the
  // pointers and count are cleared, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= data_in;
  end

  // NOTE: non-blocking assignments for all clocked state, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Power-of-two depth: natural pointer overflow is the modulo wrap.
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;

      if (rd_accept) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end

      wr_ack    <= wr_accept;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;

      case (op)
        OP_WR:   count <= count + 1'b1;
        OP_RD:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Self-checking bench for sync_fifo. A queue-based reference model tracks the
// stored words and the expected registered outputs; each scenario task drives
// the DUT and compares against the model or against directed constants.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int W = 16;
  localparam int D = 8;
  localparam int VW = W + 7;

  // {data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty}
  localparam logic [VW-1:0] RESET_VEC = {{W{1'b0}}, 7'b0000100};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_out;
  logic         wr_ack, overflow, underflow;
  logic         full, empty, almostfull, almostempty;

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] obs;
  assign obs = {data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty};

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: contents as a queue, registered outputs as plain values.
  // ---------------------------------------------------------------------------
  logic [W-1:0] q [$];
  logic [W-1:0] m_dout;
  logic         m_ack, m_ovf, m_udf;

  function automatic logic [VW-1:0] model_vec();
    int n;
    n = q.size();
    return {m_dout, m_ack, m_ovf, m_udf, (n == D), (n == 0), (n == D - 1), (n == 1)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ack  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // One clock of stimulus: drive at the falling edge, advance the model at the
  // rising edge, return 1 time unit later so outputs can be sampled.
  task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (r && !was_empty) m_dout = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    m_ack = w && !was_full;
    m_ovf = w && was_full;
    m_udf = r && was_empty;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if (obs !== RESET_VEC) $display("FAIL reset_outputs got %h want %h", obs, RESET_VEC);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, '0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL reset_release got %h want %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= D; k++) begin
      cycle(1'b1, 1'b0, W'(k));
      n_checks++;
      if (wr_ack !== 1'b1) $display("FAIL fill_wr_ack[%0d] got %b want 1", k, wr_ack);
      else n_pass++;
      n_checks++;
      if (almostfull !== (k == D - 1)) $display("FAIL fill_almostfull[%0d] got %b want %b", k, almostfull, (k == D - 1));
      else n_pass++;
      n_checks++;
      if (full !== (k == D)) $display("FAIL fill_full[%0d] got %b want %b", k, full, (k == D));
      else n_pass++;
      n_checks++;
      if (obs !== model_vec()) $display("FAIL fill_vec[%0d] got %h want %h", k, obs, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 16'hBEEF);
    n_checks++;
    if ({overflow, wr_ack, full} !== 3'b101)
      $display("FAIL overflow_flags got ovf=%b ack=%b full=%b want 1 0 1", overflow, wr_ack, full);
    else n_pass++;
    for (int k = 1; k <= D; k++) begin
      cycle(1'b0, 1'b1, '0);
      n_checks++;
      if (data_out !== W'(k)) $display("FAIL overflow_readback[%0d] got %h want %h", k, data_out, W'(k));
      else n_pass++;
      n_checks++;
      if (obs !== model_vec()) $display("FAIL overflow_vec[%0d] got %h want %h", k, obs, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    logic [W-1:0] held;
    held = data_out;
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if ({underflow, empty} !== 2'b11 || data_out !== held)
      $display("FAIL underflow got udf=%b empty=%b dout=%h want 1 1 %h", underflow, empty, data_out, held);
    else n_pass++;
    cycle(1'b0, 1'b0, '0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL underflow_clear got %h want %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, W'($urandom));
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, W'($urandom));
      n_checks++;
      if (obs !== model_vec() || q.size() != 4)
        $display("FAIL b2b_vec[%0d] got %h want %h", k, obs, model_vec());
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, '0);
      n_checks++;
      if (obs !== model_vec()) $display("FAIL b2b_drain[%0d] got %h want %h", k, obs, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous_edges();
    logic [W-1:0] first;
    cycle(1'b1, 1'b1, 16'h1234);
    n_checks++;
    if ({wr_ack, underflow, almostempty, empty} !== 4'b1110)
      $display("FAIL both_on_empty got ack=%b udf=%b ae=%b empty=%b want 1 1 1 0", wr_ack, underflow, almostempty, empty);
    else n_pass++;
    for (int k = 1; k < D; k++) cycle(1'b1, 1'b0, W'($urandom));
    first = q[0];
    n_checks++;
    if (full !== 1'b1) $display("FAIL both_prefill_full got %b want 1", full);
    else n_pass++;
    cycle(1'b1, 1'b1, 16'hDEAD);
    n_checks++;
    if ({overflow, wr_ack, almostfull, full} !== 4'b1010 || data_out !== first)
      $display("FAIL both_on_full got ovf=%b ack=%b af=%b full=%b dout=%h want 1 0 1 0 %h",
               overflow, wr_ack, almostfull, full, data_out, first);
    else n_pass++;
    while (q.size() != 0) cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL both_drain got %h want %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, W'($urandom_range(16'hFFFF, 1)));
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (q.size() != 5 || obs !== model_vec()) $display("FAIL areset_setup got %h want %h", obs, model_vec());
    else n_pass++;
    @(negedge clk);
    wr_en   = 1'b1;
    data_in = 16'h5A5A;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== RESET_VEC) $display("FAIL areset_immediate got %h want %h", obs, RESET_VEC);
    else n_pass++;
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (underflow !== 1'b1 || obs !== model_vec())
      $display("FAIL areset_first_read got %h want %h", obs, model_vec());
    else n_pass++;
    cycle(1'b1, 1'b0, 16'hC0DE);
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (data_out !== 16'hC0DE || obs !== model_vec())
      $display("FAIL areset_after got %h want %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    int pw, pr, errs;
    errs = 0;
    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0: begin pw = 80; pr = 30; end
        1: begin pw = 20; pr = 80; end
        2: begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 90; end
      endcase
      for (int k = 0; k < 100; k++) begin
        cycle(($urandom_range(99) < pw), ($urandom_range(99) < pr), W'($urandom));
        n_checks++;
        if (obs !== model_vec()) begin
          if (errs < 10) $display("FAIL random[%0d.%0d] got %h want %h", phase, k, obs, model_vec());
          errs++;
        end else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_simultaneous_edges();
    test_async_reset();
    test_random();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_sync_fifo
